// File: rtl/celement_pipe.sv
// Clocked Muller pipeline of C-element handshake stages.
// Per-stage send delay lines, ack delay, global LOPEN freeze.
module celement_pipe #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 8,
  parameter int SEND_DLY = 2,
  parameter int ACK_DLY  = 0
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             SENDIN,
  input  logic [WIDTH-1:0] DIN,
  output logic             ACKOUT,
  output logic             SENDOUT,
  output logic [WIDTH-1:0] DOUT,
  input  logic             ACKIN,
  input  logic             LOPEN,
  output logic [DEPTH-1:0] CP,
  output logic [DEPTH-1:0] OCC
);

  logic [DEPTH-1:0] c;
  logic [DEPTH-1:0] s;
  logic [DEPTH-1:0] req;
  logic [DEPTH-1:0] ack;
  logic [DEPTH-1:0] rise;
  logic [DEPTH-1:0] fall;
  logic [DEPTH-1:0] cp_q;

  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0][WIDTH-1:0] src;

  for (genvar i = 0; i < DEPTH; i++) begin : g_link
    if (i == 0) begin : g_head
      assign req[i] = SENDIN;
      assign src[i] = DIN;
    end else begin : g_body
      assign req[i] = s[i-1];
      assign src[i] = data[i-1];
    end
    if (i == DEPTH - 1) begin : g_tail
      assign ack[i] = ACKIN;
    end else begin : g_next
      assign ack[i] = c[i+1];
    end
  end

  // Every stage evaluates from pre-edge values only.
  assign rise = {DEPTH{LOPEN}} & req & ~ack & ~c;
  assign fall = {DEPTH{LOPEN}} & ~req & ack & c;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      c    <= '0;
      cp_q <= '0;
    end else begin
      c    <= (c | rise) & ~fall;
      cp_q <= rise;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      data <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rise[i]) data[i] <= src[i];
      end
    end
  end

  // Delay lines keep shifting during a freeze so s settles to c.
  if (SEND_DLY == 0) begin : g_nosd
    assign s = c;
  end else begin : g_sd
    logic [DEPTH-1:0][SEND_DLY-1:0] dl;
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        dl <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          dl[i] <= (dl[i] << 1) | SEND_DLY'(c[i]);
        end
      end
    end
    for (genvar i = 0; i < DEPTH; i++) begin : g_tap
      assign s[i] = dl[i][SEND_DLY-1];
    end
  end

  if (ACK_DLY == 0) begin : g_noad
    assign ACKOUT = c[0];
  end else begin : g_ad
    logic [ACK_DLY-1:0] ad;
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) ad <= '0;
      else         ad <= (ad << 1) | ACK_DLY'(c[0]);
    end
    assign ACKOUT = ad[ACK_DLY-1];
  end

  assign SENDOUT = s[DEPTH-1];
  assign DOUT    = data[DEPTH-1];
  assign CP      = cp_q;
  assign OCC     = c;

endmodule

// File: tb/tb_celement_pipe.sv
// Scoreboard bench for celement_pipe.
// Two instances: DEPTH=4/SEND_DLY=2 and DEPTH=1/ACK_DLY=3.
module tb_celement_pipe;

  logic       CLK;
  logic       RESETN;
  logic       lopen;

  logic       a_sendin, a_ackin, a_ackout, a_sendout;
  logic [7:0] a_din, a_dout;
  logic [3:0] a_cp, a_occ;

  logic       b_sendin, b_ackin, b_ackout, b_sendout;
  logic [7:0] b_din, b_dout;
  logic [0:0] b_cp, b_occ;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  int checks = 0;
  int errors = 0;

  celement_pipe #(
    .DEPTH(4), .WIDTH(8), .SEND_DLY(2), .ACK_DLY(0)
  ) u_a (
    .CLK(CLK), .RESETN(RESETN), .SENDIN(a_sendin), .DIN(a_din),
    .ACKOUT(a_ackout), .SENDOUT(a_sendout), .DOUT(a_dout),
    .ACKIN(a_ackin), .LOPEN(lopen), .CP(a_cp), .OCC(a_occ)
  );

  celement_pipe #(
    .DEPTH(1), .WIDTH(8), .SEND_DLY(0), .ACK_DLY(3)
  ) u_b (
    .CLK(CLK), .RESETN(RESETN), .SENDIN(b_sendin), .DIN(b_din),
    .ACKOUT(b_ackout), .SENDOUT(b_sendout), .DOUT(b_dout),
    .ACKIN(b_ackin), .LOPEN(lopen), .CP(b_cp), .OCC(b_occ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  logic a_prev = 1'b0;
  logic b_prev = 1'b0;

  always @(negedge CLK) begin
    if (!RESETN) begin
      a_prev = 1'b0;
    end else begin
      if (a_sendout && !a_prev) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_extra got %0h want none", a_dout);
        end else begin
          chk("a_dout", 32'(a_dout), 32'(qa.pop_front()));
        end
      end
      a_prev = a_sendout;
    end
  end

  always @(negedge CLK) begin
    if (!RESETN) begin
      b_prev = 1'b0;
    end else begin
      if (b_sendout && !b_prev) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_extra got %0h want none", b_dout);
        end else begin
          chk("b_dout", 32'(b_dout), 32'(qb.pop_front()));
        end
      end
      b_prev = b_sendout;
    end
  end

  task automatic produce(input logic [7:0] d);
    int n;
    a_din    = d;
    a_sendin = 1'b1;
    qa.push_back(d);
    n = 0;
    while (!a_ackout && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!a_ackout) timeout("ack_rise");
    a_sendin = 1'b0;
    n = 0;
    while (a_ackout && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (a_ackout) timeout("ack_fall");
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(qa.size() == 0 && a_occ == 4'b0
           && !a_ackin && !a_sendin)) begin
      @(negedge CLK);
      n++;
      if (a_sendin && a_ackout) a_sendin = 1'b0;
      if (a_sendout && !a_ackin) a_ackin = 1'b1;
      else if (!a_sendout && a_ackin) a_ackin = 1'b0;
    end
    if (n >= budget) timeout("drain");
  endtask

  initial begin
    logic [3:0] exp_cp;
    logic [3:0] occ_frz;
    logic       saw;
    logic       bad;
    int         first;

    RESETN   = 1'b0;
    lopen    = 1'b1;
    a_sendin = 1'b0;
    a_ackin  = 1'b0;
    a_din    = 8'h00;
    b_sendin = 1'b0;
    b_ackin  = 1'b0;
    b_din    = 8'h00;

    repeat (3) @(negedge CLK);
    chk("rst_a", 32'({a_ackout, a_sendout, a_cp, a_occ, a_dout}), 32'h0);
    chk("rst_b", 32'({b_ackout, b_sendout, b_cp, b_occ, b_dout}), 32'h0);
    #2 RESETN = 1'b1;

    // single token through DEPTH=4, SEND_DLY=2
    @(negedge CLK);
    a_din    = 8'h5A;
    a_sendin = 1'b1;
    qa.push_back(8'h5A);
    for (int r = 1; r <= 13; r++) begin
      @(negedge CLK);
      exp_cp = (r == 1) ? 4'b0001 :
               (r == 4) ? 4'b0010 :
               (r == 7) ? 4'b0100 :
               (r == 10) ? 4'b1000 : 4'b0000;
      chk($sformatf("tok_r%0d", r),
          32'({a_ackout, a_sendout, a_cp}),
          32'({1'b1, (r >= 12), exp_cp}));
    end

    // asynchronous reset with tokens in flight
    #2 RESETN = 1'b0;
    #1;
    chk("rst_mid", 32'({a_ackout, a_sendout, a_cp, a_occ, a_dout}), 32'h0);
    qa.delete();
    a_sendin = 1'b0;
    @(negedge CLK);
    #2 RESETN = 1'b1;
    @(negedge CLK);
    chk("rst_occ", 32'(a_occ), 32'h0);

    // fill with the consumer blocked
    produce(8'hA1);
    produce(8'hB2);
    repeat (40) @(negedge CLK);
    chk("fill_occ", 32'(a_occ), 32'hA);
    chk("fill_dout", 32'(a_dout), 32'hA1);
    a_din    = 8'hC3;
    a_sendin = 1'b1;
    qa.push_back(8'hC3);
    saw = 1'b0;
    repeat (30) begin
      @(negedge CLK);
      saw = saw | a_ackout;
    end
    chk("full_noack", 32'(saw), 32'h0);

    drain(400);
    chk("drain_q", 32'(qa.size()), 32'h0);
    chk("drain_occ", 32'(a_occ), 32'h0);

    // 20-cycle freeze while stage 1 is about to capture
    @(negedge CLK);
    a_din    = 8'hD4;
    a_sendin = 1'b1;
    qa.push_back(8'hD4);
    first = 0;
    bad   = 1'b0;
    occ_frz = 4'b0;
    for (int r = 1; r <= 40; r++) begin
      @(negedge CLK);
      if (r == 3) begin
        chk("frz_occ0", 32'(a_occ), 32'h1);
        occ_frz = a_occ;
        lopen = 1'b0;
      end
      if (r >= 4 && r <= 23) begin
        if (a_cp != 4'b0 || a_occ != occ_frz) bad = 1'b1;
      end
      if (r == 23) lopen = 1'b1;
      if (r == 24) chk("frz_cp1", 32'(a_cp), 32'h2);
      if (a_sendout && first == 0) first = r;
    end
    chk("frz_hold", 32'(bad), 32'h0);
    chk("frz_lat", 32'(first), 32'd32);
    drain(400);
    chk("frz_occ", 32'(a_occ), 32'h0);

    // DEPTH=1, SEND_DLY=0, ACK_DLY=3
    @(negedge CLK);
    b_din    = 8'h3C;
    b_sendin = 1'b1;
    qb.push_back(8'h3C);
    for (int r = 1; r <= 4; r++) begin
      @(negedge CLK);
      chk($sformatf("b_r%0d", r),
          32'({b_sendout, b_ackout, b_cp}),
          32'({1'b1, (r >= 4), (r == 1)}));
    end
    b_sendin = 1'b0;
    b_ackin  = 1'b1;
    @(negedge CLK);
    chk("b_fall", 32'({b_sendout, b_occ}), 32'h0);
    b_ackin = 1'b0;
    repeat (5) @(negedge CLK);
    chk("b_ack0", 32'(b_ackout), 32'h0);

    chk("qa_end", 32'(qa.size()), 32'h0);
    chk("qb_end", 32'(qb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
